dxc_cap_buffer: RTL and testbench
=================================

# dxc_cap_buffer

Snapshot capture buffer on the DxC subsystem's selected-capture stream (valid / 32-bit data / 3-bit channel). It records a programmable number of samples into on-chip RAM, either immediately or from the next radio-frame pulse, and exposes the buffer and control/status registers through an Avalon-MM slave. Software reads these over the lightweight HPS bridge. It sits on the DSP clock domain beside the DxC subsystem.

## Interface

- DEPTH, 1024: buffer depth in samples; power of two, 16..4096.
- AW, $clog2(DEPTH): buffer address width.

- dsp_in_clk_clk  in  1  sole clock; all logic is on this clock.
- dsp_in_reset_reset_n  in  1  asynchronous, active-low reset.
- cap_valid  in  1  capture sample valid; no backpressure.
- cap_data  in  32  sample, {I[15:0], Q[15:0]}, stored verbatim.
- cap_channel  in  3  sample channel tag.
- rfp_pulse_data  in  1  radio frame pulse; the rising edge is the trigger.
- s0_address  in  AW+1  word address; bit AW=1 selects RAM, 0 selects CSR.
- s0_read  in  1  read strobe.
- s0_write  in  1  write strobe.
- s0_writedata  in  32  write data.
- s0_readdata  out  32  read data.
- s0_readdatavalid  out  1  read data qualifier.
- s0_waitrequest  out  1  tied 0.

## Operation

- CSR word offsets:
  - 0 CTRL: bit0 ARM (write-1 pulse, reads 0); bit1 ABORT (write-1 pulse, reads 0); bit2 TRIG_MODE (0 immediate, 1 wait for RFP); bit3 CH_FILT_EN; bits[6:4] CH_SEL.
  - 1 STATUS (RO): bits[1:0] state; bit2 DONE.
  - 2 LENGTH: bits[AW:0]; 0 or any value >DEPTH means DEPTH.
  - 3 COUNT (RO): samples written.
  - Offsets 4+ read 0; writes to them are ignored.
- FSM states: IDLE=0, WAIT_TRIG=1, CAPTURE=2, DONE=3.
  - IDLE/DONE + ARM: clear COUNT, latch effective length, and go to WAIT_TRIG if TRIG_MODE=1, otherwise CAPTURE.
  - WAIT_TRIG + RFP rising edge: go to CAPTURE. The edge is detected from a registered copy of rfp_pulse_data.
  - CAPTURE: a sample is accepted when cap_valid and (!CH_FILT_EN or cap_channel==CH_SEL). An accepted sample is written to RAM[COUNT] and COUNT increments. When COUNT reaches the latched length, go to DONE.
  - ABORT from any state goes to IDLE. COUNT and RAM contents are preserved.
  - ARM in WAIT_TRIG or CAPTURE is ignored.
  - ARM and ABORT in the same write: ABORT wins.
- DONE bit = (state==DONE).
- COUNT never exceeds DEPTH, and the write address never wraps.
- CTRL and LENGTH changes during capture do not affect the active capture. The filter fields do take effect on the next cycle.
- RAM region:
  - Read-only; writes are ignored.
  - Reads during capture are legal and return current contents.
- Reset values:
  - s0_readdata=0, s0_readdatavalid=0, s0_waitrequest=0.
  - State IDLE; CTRL, LENGTH and COUNT are 0.
  - RAM contents are undefined.

## Timing

- Read latency is fixed at 2 cycles for both CSR and RAM. A read at cycle t gives s0_readdatavalid=1 with data at t+2.
  - Back-to-back reads are fully pipelined, one per cycle.
  - s0_readdata is held between valids.
- Write latency:
  - A CSR write at t is visible to a read issued at t+1.
  - An ARM write at t leaves state ≠ IDLE at t+1.
- Capture timing:
  - A sample accepted at t is written at t+1.
  - COUNT is updated at t+1.
  - The transition to DONE happens at t+1 for the final sample.
- Trigger timing:
  - An rfp_pulse_data rising edge sampled at t is detected at t+1.
  - CAPTURE is entered at t+2.
  - The first eligible sample is at t+2.
- A sample arriving on the same cycle as the final write is not captured.
- Reset asserted mid-capture returns everything to reset values immediately.

## Structure

- Package dxc_cap_pkg holds:
  - the state enum;
  - the CSR offsets;
  - the CTRL and STATUS bit positions;
  - the sample width constant (32).
- Sub-module dxc_cap_ram: simple dual-port RAM with one write port and one read port, registered address and registered output, DEPTH×32, giving 2-cycle read latency.
- The top contains the FSM, counters, RFP edge detect, CSR decode and read mux. The CSR path is pipelined to match RAM latency.

## Test plan

- Immediate capture:
  - Stimulus: LENGTH=8, TRIG_MODE=0, ARM, then 10 continuous valid samples with data 0x1000+n.
  - Response: DONE; COUNT=8; RAM[0..7]=0x1000..0x1007; RAM[8] unwritten.
- RFP trigger:
  - Stimulus: TRIG_MODE=1, ARM, valids streaming, rfp rising edge at cycle T.
  - Response: state=1 until T+1; RAM[0] is the sample at T+2.
- Channel filter:
  - Stimulus: CH_FILT_EN=1, CH_SEL=5, channels cycling 0..7, LENGTH=4.
  - Response: RAM holds only the channel-5 samples, 4 of them.
- Abort:
  - Stimulus: ABORT mid-capture after 3 samples, then ARM together with ABORT in a single write.
  - Response: state=IDLE; COUNT=3; the second write leaves state IDLE.
- Length limits:
  - Stimulus: LENGTH=0 and LENGTH=DEPTH+5.
  - Response: exactly DEPTH samples; COUNT=DEPTH; no wrap over RAM[0].
- Read pipeline:
  - Stimulus: back-to-back reads of CSR 3, RAM 0 and CSR 7.
  - Response: readdatavalid at t+2, t+3 and t+4 with the correct data; CSR 7 returns 0; waitrequest always 0.

Source files
------------

// File: rtl/dxc_cap_buffer_pkg.sv
// Shared types and constants for the DxC snapshot capture buffer:
// FSM states, CSR map, CTRL/STATUS bit positions and sample width.
package dxc_cap_pkg;

  localparam int SAMPLE_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TRIG = 2'd1,
    ST_CAPTURE   = 2'd2,
    ST_DONE      = 2'd3
  } cap_state_e;

  // CSR word offsets
  localparam int CSR_CTRL   = 0;
  localparam int CSR_STATUS = 1;
  localparam int CSR_LENGTH = 2;
  localparam int CSR_COUNT  = 3;

  // CTRL bit positions
  localparam int CTRL_ARM        = 0;
  localparam int CTRL_ABORT      = 1;
  localparam int CTRL_TRIG_MODE  = 2;
  localparam int CTRL_CH_FILT_EN = 3;
  localparam int CTRL_CH_SEL_LSB = 4;
  localparam int CH_SEL_W        = 3;

  // STATUS bit positions
  localparam int STATUS_STATE_LSB = 0;
  localparam int STATUS_DONE      = 2;

  typedef struct packed {
    logic [CH_SEL_W-1:0] ch_sel;
    logic                ch_filt_en;
    logic                trig_mode;
  } ctrl_t;

  // ARM and ABORT are pulses and always read back as 0.
  function automatic logic [SAMPLE_W-1:0] pack_ctrl(input ctrl_t c);
    logic [SAMPLE_W-1:0] w;
    w = '0;
    w[CTRL_TRIG_MODE]                  = c.trig_mode;
    w[CTRL_CH_FILT_EN]                 = c.ch_filt_en;
    w[CTRL_CH_SEL_LSB +: CH_SEL_W]     = c.ch_sel;
    return w;
  endfunction

endpackage

// File: rtl/dxc_cap_buffer_if.sv
// Avalon-MM slave bundle for the capture buffer (word addressed,
// bit AW of the address selects RAM over CSR).
interface dxc_cap_avmm_if #(
  parameter int AW = 10
);
  import dxc_cap_pkg::*;

  logic [AW:0]         address;
  logic                read;
  logic                write;
  logic [SAMPLE_W-1:0] writedata;
  logic [SAMPLE_W-1:0] readdata;
  logic                readdatavalid;
  logic                waitrequest;

  modport master (
    output address, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );

endinterface

// File: rtl/dxc_cap_buffer_ram.sv
// Simple dual-port sample RAM: one write port, one read port with
// registered address and registered output (2-cycle read latency).
module dxc_cap_ram
  import dxc_cap_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [SAMPLE_W-1:0] wdata,
  input  logic                re,
  input  logic [AW-1:0]       raddr,
  output logic [SAMPLE_W-1:0] rdata
);

  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [AW-1:0]       raddr_q;
  logic                re_q;

  // NOTE: the array has no reset so it maps onto block RAM; only the
  // surrounding pipeline registers are reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // rdata only moves when a read is in flight, so it holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raddr_q <= '0;
      re_q    <= 1'b0;
      rdata   <= '0;
    end else begin
      re_q <= re;
      if (re)   raddr_q <= raddr;
      if (re_q) rdata   <= mem[raddr_q];
    end
  end

endmodule

// File: rtl/dxc_cap_buffer.sv
// Snapshot capture buffer: FSM, sample counter, RFP edge detect and an
// Avalon-MM CSR/RAM read path with a fixed 2-cycle read latency.
module dxc_cap_buffer
  import dxc_cap_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                dsp_in_clk_clk,
  input  logic                dsp_in_reset_reset_n,
  input  logic                cap_valid,
  input  logic [SAMPLE_W-1:0] cap_data,
  input  logic [2:0]          cap_channel,
  input  logic                rfp_pulse_data,
  input  logic [AW:0]         s0_address,
  input  logic                s0_read,
  input  logic                s0_write,
  input  logic [SAMPLE_W-1:0] s0_writedata,
  output logic [SAMPLE_W-1:0] s0_readdata,
  output logic                s0_readdatavalid,
  output logic                s0_waitrequest
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic clk;
  logic rst_n;
  assign clk   = dsp_in_clk_clk;
  assign rst_n = dsp_in_reset_reset_n;

  dxc_cap_avmm_if #(.AW(AW)) bus ();

  assign bus.address      = s0_address;
  assign bus.read         = s0_read;
  assign bus.write        = s0_write;
  assign bus.writedata    = s0_writedata;
  assign s0_readdata      = bus.readdata;
  assign s0_readdatavalid = bus.readdatavalid;
  assign s0_waitrequest   = bus.waitrequest;

  // ---------------------------------------------------------------- CSR write
  logic [AW-1:0] csr_off;
  logic          csr_wr, ctrl_wr, length_wr;
  logic          arm_req, abort_req, arm_trig;
  logic          unused_wdata;

  assign csr_off   = bus.address[AW-1:0];
  assign csr_wr    = bus.write && !bus.address[AW];
  assign ctrl_wr   = csr_wr && (csr_off == AW'(CSR_CTRL));
  assign length_wr = csr_wr && (csr_off == AW'(CSR_LENGTH));
  assign arm_req   = ctrl_wr && bus.writedata[CTRL_ARM];
  assign abort_req = ctrl_wr && bus.writedata[CTRL_ABORT];
  assign arm_trig  = bus.writedata[CTRL_TRIG_MODE];
  assign unused_wdata = ^bus.writedata[SAMPLE_W-1:7];

  ctrl_t       ctrl_q;
  logic [AW:0] length_q;

  // NOTE: every register here uses <= so all flops sample the pre-edge
  // values; blocking assignments would make results depend on block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q   <= '0;
      length_q <= '0;
    end else begin
      if (ctrl_wr) begin
        ctrl_q.trig_mode  <= bus.writedata[CTRL_TRIG_MODE];
        ctrl_q.ch_filt_en <= bus.writedata[CTRL_CH_FILT_EN];
        ctrl_q.ch_sel     <= bus.writedata[CTRL_CH_SEL_LSB +: CH_SEL_W];
      end
      if (length_wr) length_q <= bus.writedata[AW:0];
    end
  end

  // ---------------------------------------------------------------- RFP edge
  logic rfp_q, rfp_q2, rfp_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rfp_q  <= 1'b0;
      rfp_q2 <= 1'b0;
    end else begin
      rfp_q  <= rfp_pulse_data;
      rfp_q2 <= rfp_q;
    end
  end

  assign rfp_rise = rfp_q && !rfp_q2;

  // ---------------------------------------------------------------- FSM
  cap_state_e  state_q, state_d;
  logic [AW:0] count_q, count_inc, eff_len_q, eff_len_c;
  logic        sample_hit, start, accept;

  // Zero or oversize lengths mean a full buffer.
  assign eff_len_c  = (length_q == '0 || length_q > DEPTH_W) ? DEPTH_W : length_q;
  assign count_inc  = count_q + (AW+1)'(1);
  assign sample_hit = cap_valid &&
                      (!ctrl_q.ch_filt_en || cap_channel == ctrl_q.ch_sel);

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    accept  = 1'b0;
    if (abort_req) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm_req) begin
            start   = 1'b1;
            state_d = arm_trig ? ST_WAIT_TRIG : ST_CAPTURE;
          end
        end
        ST_WAIT_TRIG: begin
          if (rfp_rise) state_d = ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (sample_hit) begin
            accept = 1'b1;
            if (count_inc == eff_len_q) state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      eff_len_q <= DEPTH_W;
    end else begin
      state_q <= state_d;
      if (start) begin
        count_q   <= '0;
        eff_len_q <= eff_len_c;
      end else if (accept) begin
        count_q <= count_inc;
      end
    end
  end

  // ---------------------------------------------------------------- RAM
  logic                ram_re;
  logic [SAMPLE_W-1:0] ram_rdata;

  assign ram_re = bus.read && bus.address[AW];

  // count_q < eff_len_q <= DEPTH whenever accept is high, so no wrap.
  dxc_cap_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (accept),
    .waddr (count_q[AW-1:0]),
    .wdata (cap_data),
    .re    (ram_re),
    .raddr (bus.address[AW-1:0]),
    .rdata (ram_rdata)
  );

  // ---------------------------------------------------------------- read path
  logic [SAMPLE_W-1:0] csr_rdata;

  always_comb begin
    csr_rdata = '0;
    case (csr_off)
      AW'(CSR_CTRL):   csr_rdata = pack_ctrl(ctrl_q);
      AW'(CSR_STATUS): begin
        csr_rdata[STATUS_STATE_LSB +: 2] = state_q;
        csr_rdata[STATUS_DONE]           = (state_q == ST_DONE);
      end
      AW'(CSR_LENGTH): csr_rdata[AW:0] = length_q;
      AW'(CSR_COUNT):  csr_rdata[AW:0] = count_q;
      default:         csr_rdata = '0;
    endcase
  end

  // Two CSR stages mirror the RAM's address and output registers.
  logic                rd_v1, rd_v2, sel_ram1, sel_ram2;
  logic [SAMPLE_W-1:0] csr1, csr2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v1    <= 1'b0;
      rd_v2    <= 1'b0;
      sel_ram1 <= 1'b0;
      sel_ram2 <= 1'b0;
      csr1     <= '0;
      csr2     <= '0;
    end else begin
      rd_v1 <= bus.read;
      rd_v2 <= rd_v1;
      if (bus.read) begin
        sel_ram1 <= bus.address[AW];
        csr1     <= csr_rdata;
      end
      if (rd_v1) begin
        sel_ram2 <= sel_ram1;
        csr2     <= csr1;
      end
    end
  end

  assign bus.readdata      = sel_ram2 ? ram_rdata : csr2;
  assign bus.readdatavalid = rd_v2;
  assign bus.waitrequest   = 1'b0;

endmodule

// File: tb/tb_dxc_cap_buffer.sv
// Scoreboard bench for dxc_cap_buffer: reads push expected data and due
// cycle into a queue; a negedge monitor pops and compares on readdatavalid.
module tb_dxc_cap_buffer;
  import dxc_cap_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cap_valid = 1'b0;
  logic [31:0] cap_data = '0;
  logic [2:0]  cap_channel = '0;
  logic        rfp = 1'b0;

  always #5 clk = ~clk;

  dxc_cap_avmm_if #(.AW(AW)) av ();

  dxc_cap_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .dsp_in_clk_clk       (clk),
    .dsp_in_reset_reset_n (rst_n),
    .cap_valid            (cap_valid),
    .cap_data             (cap_data),
    .cap_channel          (cap_channel),
    .rfp_pulse_data       (rfp),
    .s0_address           (av.address),
    .s0_read              (av.read),
    .s0_write             (av.write),
    .s0_writedata         (av.writedata),
    .s0_readdata          (av.readdata),
    .s0_readdatavalid     (av.readdatavalid),
    .s0_waitrequest       (av.waitrequest)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: data and arrival cycle of every read response.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && av.readdatavalid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_rdv: got readdatavalid=1 expected no read pending");
      end else begin
        e = exp_q.pop_front();
        check(e.name, av.readdata, e.data);
        check({e.name, "_lat"}, cyc, e.due);
      end
    end
  end

  function automatic logic [AW:0] csr(input int o);
    logic [AW:0] a;
    a = {1'b0, AW'(o)};
    return a;
  endfunction

  function automatic logic [AW:0] ram(input int i);
    logic [AW:0] a;
    a = {1'b1, AW'(i)};
    return a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_rd(input logic [AW:0] a, input logic [31:0] e, input string n);
    av.read    = 1'b1;
    av.address = a;
    exp_q.push_back('{name: n, data: e, due: cyc + 2});
  endtask

  task automatic rd(input logic [AW:0] a, input logic [31:0] e, input string n);
    issue_rd(a, e, n);
    tick();
    av.read = 1'b0;
  endtask

  task automatic wr(input logic [AW:0] a, input logic [31:0] d);
    av.write     = 1'b1;
    av.address   = a;
    av.writedata = d;
    tick();
    av.write = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      tick();
      k++;
    end
    check("drain_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic stream(input int n, input logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      cap_valid   = 1'b1;
      cap_data    = base + k;
      cap_channel = k[2:0];
      tick();
    end
    cap_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    av.address   = '0;
    av.read      = 1'b0;
    av.write     = 1'b0;
    av.writedata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_readdata", av.readdata, 32'h0);
    check("rst_rdv", {31'b0, av.readdatavalid}, 32'h0);
    check("rst_waitreq", {31'b0, av.waitrequest}, 32'h0);
    rst_n = 1'b1;
    tick();
    rd(csr(CSR_CTRL), 32'h0, "rst_ctrl");
    rd(csr(CSR_STATUS), 32'h0, "rst_status");
    rd(csr(CSR_LENGTH), 32'h0, "rst_length");
    rd(csr(CSR_COUNT), 32'h0, "rst_count");
    drain();

    // LENGTH=0 means DEPTH; extra samples must not wrap over RAM[0]
    wr(csr(CSR_LENGTH), 32'd0);
    wr(csr(CSR_CTRL), 32'h1);
    stream(20, 32'hA000);
    rd(csr(CSR_STATUS), 32'h7, "len0_status");
    rd(csr(CSR_COUNT), 32'd16, "len0_count");
    rd(csr(CSR_LENGTH), 32'd0, "len0_length");
    rd(ram(0), 32'hA000, "len0_ram0");
    rd(ram(15), 32'hA00F, "len0_ram15");
    drain();

    // LENGTH above DEPTH also means DEPTH
    wr(csr(CSR_LENGTH), 32'd21);
    rd(csr(CSR_LENGTH), 32'd21, "lenbig_length");
    wr(csr(CSR_CTRL), 32'h1);
    stream(20, 32'hB000);
    rd(csr(CSR_COUNT), 32'd16, "lenbig_count");
    rd(ram(0), 32'hB000, "lenbig_ram0");
    rd(ram(15), 32'hB00F, "lenbig_ram15");
    rd(csr(CSR_STATUS), 32'h7, "lenbig_status");
    drain();

    // Immediate capture, LENGTH=8, 10 samples offered
    wr(csr(CSR_LENGTH), 32'd8);
    wr(csr(CSR_CTRL), 32'h1);
    stream(10, 32'h1000);
    rd(csr(CSR_STATUS), 32'h7, "imm_status");
    rd(csr(CSR_COUNT), 32'd8, "imm_count");
    for (int i = 0; i < 8; i++) rd(ram(i), 32'h1000 + i, $sformatf("imm_ram%0d", i));
    rd(ram(8), 32'hB008, "imm_ram8_untouched");
    drain();

    // RFP trigger: edge at k=3, first captured sample is k=5
    wr(csr(CSR_CTRL), 32'h5);
    rd(csr(CSR_STATUS), 32'h1, "rfp_wait_status");
    for (int k = 0; k < 16; k++) begin
      cap_valid   = 1'b1;
      cap_data    = 32'h2000 + k;
      cap_channel = k[2:0];
      rfp         = (k >= 3 && k <= 5);
      av.read     = 1'b0;
      if (k == 4) issue_rd(csr(CSR_STATUS), 32'h1, "rfp_status_t1");
      if (k == 5) issue_rd(csr(CSR_STATUS), 32'h2, "rfp_status_t2");
      tick();
    end
    cap_valid = 1'b0;
    rfp       = 1'b0;
    av.read   = 1'b0;
    rd(csr(CSR_STATUS), 32'h7, "rfp_done_status");
    rd(csr(CSR_COUNT), 32'd8, "rfp_count");
    rd(ram(0), 32'h2005, "rfp_ram0");
    rd(ram(7), 32'h200C, "rfp_ram7");
    drain();

    // Channel filter: only channel 5 samples, 4 of them
    wr(csr(CSR_LENGTH), 32'd4);
    wr(csr(CSR_CTRL), 32'h59);
    stream(32, 32'h3000);
    rd(ram(0), 32'h3005, "filt_ram0");
    rd(ram(1), 32'h300D, "filt_ram1");
    rd(ram(2), 32'h3015, "filt_ram2");
    rd(ram(3), 32'h301D, "filt_ram3");
    rd(ram(4), 32'h2009, "filt_ram4_untouched");
    rd(csr(CSR_COUNT), 32'd4, "filt_count");
    rd(csr(CSR_STATUS), 32'h7, "filt_status");
    rd(csr(CSR_CTRL), 32'h58, "filt_ctrl_readback");
    drain();

    // Abort after 3 samples, then ARM+ABORT together
    wr(csr(CSR_LENGTH), 32'd8);
    wr(csr(CSR_CTRL), 32'h1);
    stream(3, 32'h4000);
    wr(csr(CSR_CTRL), 32'h2);
    rd(csr(CSR_STATUS), 32'h0, "abort_status");
    rd(csr(CSR_COUNT), 32'd3, "abort_count");
    wr(csr(CSR_CTRL), 32'h3);
    rd(csr(CSR_STATUS), 32'h0, "armabort_status");
    rd(csr(CSR_COUNT), 32'd3, "armabort_count");
    for (int i = 0; i < 3; i++) rd(ram(i), 32'h4000 + i, $sformatf("abort_ram%0d", i));
    rd(ram(3), 32'h301D, "abort_ram3_untouched");
    drain();

    // RAM writes and unmapped CSR writes are ignored
    wr(ram(0), 32'hDEADBEEF);
    wr(csr(4), 32'h1234);
    rd(csr(4), 32'h0, "csr4_reads0");
    drain();

    // Back-to-back reads, one per cycle
    issue_rd(csr(CSR_COUNT), 32'd3, "pipe_csr3");
    tick();
    issue_rd(ram(0), 32'h4000, "pipe_ram0");
    check("pipe_waitreq", {31'b0, av.waitrequest}, 32'h0);
    tick();
    issue_rd(csr(7), 32'h0, "pipe_csr7");
    tick();
    av.read = 1'b0;
    drain();

    // readdata holds between valids
    rd(ram(1), 32'h4001, "hold_ram1");
    drain();
    repeat (3) tick();
    check("hold_readdata", av.readdata, 32'h4001);
    check("hold_rdv", {31'b0, av.readdatavalid}, 32'h0);

    // Reset in mid-capture
    wr(csr(CSR_CTRL), 32'h1);
    cap_valid = 1'b1;
    cap_data  = 32'h5000;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_readdata", av.readdata, 32'h0);
    check("midrst_rdv", {31'b0, av.readdatavalid}, 32'h0);
    cap_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    rd(csr(CSR_STATUS), 32'h0, "midrst_status");
    rd(csr(CSR_COUNT), 32'h0, "midrst_count");
    rd(csr(CSR_LENGTH), 32'h0, "midrst_length");
    rd(csr(CSR_CTRL), 32'h0, "midrst_ctrl");
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
